// File: rtl/button_pulse_pkg.sv
// Shared definitions for the push-button conditioner: channel count, debounce
// counter width and the per-channel debounce FSM encoding.
// Optional BTN_INVERT_EN (used by button_pulse) makes btn_raw active-low.
package button_pulse_pkg;

  // Number of independent push-button channels.
  localparam int NUM_BUTTONS = 5;

  // Width of the per-channel stability counter.
  localparam int CNT_W = 20;

  // Debounce FSM states, 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // The debounced level is high while the button is accepted as pressed,
  // which includes the window where a release is still being qualified.
  function automatic logic state_is_pressed(input btn_state_e st);
    return (st == ST_HELD) || (st == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and debounce FSM.
// Press event is combinational on the accepting cycle; level is registered.
// No handshake: the press event is a one-cycle strobe the parent must sample.
module btn_debounce
  import button_pulse_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = DEBOUNCE_CYCLES - CNT_ONE;

  logic             sync1_q;
  logic             sync2_q;
  btn_state_e       state_q;
  btn_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             cnt_done;

  // Two-flop synchroniser bringing the asynchronous pin into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  assign cnt_done = (cnt_q == CNT_LAST);

  // FSM state, stability counter and debounced level registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Next-state logic: the counter only runs in the two WAIT states and is
  // cleared on every transition, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sync2_q) begin
          state_d = ST_PRESS_WAIT;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        cnt_d = '0;
        if (!sync2_q) begin
          state_d = ST_RELEASE_WAIT;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync2_q) begin
          // Bounce during release: back to held without a second press.
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = state_is_pressed(state_d);
  end

  assign level_o = level_q;

endmodule

// File: rtl/button_pulse.sv
// Push-button conditioner: per-button sync, debounce and press-edge pulse.
// Latency: pulse and level rise DEBOUNCE_CYCLES+2 edges after the first high sample.
// No backpressure: button is a one-cycle strobe; pulses with enable low are dropped.
// Optional BTN_INVERT_EN: btn_raw is active-low (inverted before the synchroniser).
module button_pulse
  import button_pulse_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd100_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] button,
  output logic [NUM_BUTTONS-1:0] btn_level
);

  logic [NUM_BUTTONS-1:0] btn_act;
  logic [NUM_BUTTONS-1:0] press_evt;
  logic [NUM_BUTTONS-1:0] button_q;
  logic [NUM_BUTTONS-1:0] button_d;

  // Normalise pin polarity so every channel sees pressed = 1; reset state
  // of the synchroniser (0) therefore always means released.
`ifdef BTN_INVERT_EN
  assign btn_act = ~btn_raw;
`else
  assign btn_act = btn_raw;
`endif

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_act[g]),
      .press_o (press_evt[g]),
      .level_o (btn_level[g])
    );
  end

  // Gate press events with enable in the cycle they fire; nothing is deferred,
  // so a button held across an enable rise stays silent until re-pressed.
  always_comb begin
    button_d = press_evt & {NUM_BUTTONS{enable}};
  end

  // Register the pulses so they align with the debounced level rising.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      button_q <= '0;
    end else begin
      button_q <= button_d;
    end
  end

  assign button = button_q;

endmodule

// File: tb/tb_button_pulse.sv
// Bench for button_pulse: directed scenarios plus random pin activity, checked
// every cycle through a scoreboard fed by a sliding-window reference model.
// Honors BTN_INVERT_EN by driving the pins with the matching polarity.
module tb_button_pulse;

  localparam int D  = 4;
  localparam int NB = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [NB-1:0] press = '0;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] button;
  logic [NB-1:0] btn_level;

`ifdef BTN_INVERT_EN
  assign btn_raw = ~press;
`else
  assign btn_raw = press;
`endif

  button_pulse #(
    .DEBOUNCE_CYCLES(20'(D))
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .btn_raw   (btn_raw),
    .button    (button),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NB-1:0]   hist[$];
  logic [NB-1:0]   m_lvl = '0;
  logic [2*NB-1:0] sb[$];
  int              pulse_cnt[NB];
  int              simul_cnt = 0;
  int              base_cnt[NB];
  int              base_simul;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button is accepted as pressed once D+1 consecutive
  // logical samples are 1 (released: D+1 consecutive 0s); the decision at an
  // edge sees samples two edges old because of the synchroniser.
  always @(posedge clk) begin
    logic [NB-1:0] all1, all0, rise, fall, exp_btn;
    exp_btn = '0;
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < D + 3; i++) hist.push_back('0);
      m_lvl = '0;
    end else begin
      hist.push_back(press);
      void'(hist.pop_front());
      all1 = '1;
      all0 = '1;
      for (int j = 0; j <= D; j++) begin
        all1 &= hist[j];
        all0 &= ~hist[j];
      end
      rise    = ~m_lvl & all1;
      fall    = m_lvl & all0;
      m_lvl   = (m_lvl | rise) & ~fall;
      exp_btn = rise & {NB{enable}};
    end
    sb.push_back({exp_btn, m_lvl});
  end

  // Monitor: outputs are presented every cycle; compare away from the edge.
  always @(negedge clk) begin
    logic [2*NB-1:0] e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("button", 32'(button), 32'(e[2*NB-1:NB]));
      check("btn_level", 32'(btn_level), 32'(e[NB-1:0]));
      for (int i = 0; i < NB; i++) if (button[i] === 1'b1) pulse_cnt[i]++;
      if (button === 5'b10010) simul_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    for (int i = 0; i < NB; i++) base_cnt[i] = pulse_cnt[i];
    base_simul = simul_cnt;
  endtask

  function automatic int pulses(input int b);
    return pulse_cnt[b] - base_cnt[b];
  endfunction

  initial begin
    for (int i = 0; i < NB; i++) pulse_cnt[i] = 0;

    // Reset with all buttons pressed, gameplay disabled.
    rst_n  = 1'b0;
    enable = 1'b0;
    press  = 5'b11111;
    snap();
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    press = '0;
    cyc(10);
    for (int i = 0; i < NB; i++) check("reset_no_pulse", 32'(pulses(i)), 0);

    // Clean press and release of bit 2.
    enable = 1'b1;
    snap();
    press[2] = 1'b1;
    cyc(10);
    press[2] = 1'b0;
    cyc(10);
    check("clean_pulse_b2", 32'(pulses(2)), 1);

    // Bouncing bit 0, then a stable hold.
    snap();
    press[0] = 1'b1; cyc(3);
    press[0] = 1'b0; cyc(1);
    press[0] = 1'b1; cyc(3);
    check("bounce_no_pulse", 32'(pulses(0)), 0);
    cyc(10);
    check("bounce_then_hold", 32'(pulses(0)), 1);
    press[0] = 1'b0;
    cyc(10);

    // Simultaneous press of bits 1 and 4.
    snap();
    press = 5'b10010;
    cyc(10);
    press = '0;
    cyc(10);
    check("simul_cycles", 32'(simul_cnt - base_simul), 1);

    // Enable gating on bit 3.
    snap();
    enable   = 1'b0;
    press[3] = 1'b1;
    cyc(10);
    check("gate_no_pulse", 32'(pulses(3)), 0);
    check("gate_level", 32'(btn_level[3]), 1);
    enable = 1'b1;
    cyc(10);
    check("gate_enable_while_held", 32'(pulses(3)), 0);
    press[3] = 1'b0; cyc(10);
    press[3] = 1'b1; cyc(10);
    check("gate_repress", 32'(pulses(3)), 1);
    press[3] = 1'b0; cyc(10);

    // Reset in the middle of a press qualification.
    snap();
    press[0] = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    check("rst_mid_no_early", 32'(pulses(0)), 0);
    cyc(8);
    check("rst_mid_one_pulse", 32'(pulses(0)), 1);
    press[0] = 1'b0;
    cyc(10);

    // Random pin activity with occasional enable toggles and resets.
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 4) == 0) press[b] = ~press[b];
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      rst_n = ($urandom_range(0, 199) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    press = '0;
    cyc(12);
    check("sb_drained", 32'(sb.size() < 2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
